load_reg_sequencer: RTL
=======================

# load_reg_sequencer

Controller that shares the 8-bit parallel-load register between two requesters and sequences each transfer. It arbitrates round-robin and drives the register's parallel inputs and `load` strobe for one cycle. It then serialises the captured word LSB-first under a bit counter and signals completion. It sits directly in front of the existing parallel-load register in the lab datapath.

## Interface
- `WIDTH`, 8: register width in bits; legal range 2..32.
- `clock`  in  1  rising-edge clock, the only clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req0`  in  1  requester 0 wants a transfer; held until `ack0`.
- `data0`  in  WIDTH  requester 0 word; stable while `req0` is high.
- `ack0`  out  1  grant to requester 0; a handshake completes on the rising edge where `req0 && ack0`.
- `req1`, `data1`, `ack1`: same as above, for requester 1.
- `load`  out  1  one-cycle parallel-load strobe to the register.
- `reg_in`  out  WIDTH  parallel data to the register (drives in1..inN); bit 0 = in1.
- `shift_en`  out  1  high during serial phase.
- `ser_out`  out  1  current serial bit.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `owner`  out  1  requester id of the current or last transfer.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- Reset values: state = IDLE, round-robin pointer = 0, counter = 0, captured word = 0, `owner` = 0. All outputs are 0.
- IDLE
  - `ack0` and `ack1` are combinational from `req0`/`req1` and the pointer. At most one ack is high.
  - Sole requester wins.
  - If both request, the requester not served last wins. After reset, requester 0 wins.
  - On handshake: capture `dataN`, set `owner` = N, update the pointer to N, go to LOAD.
- LOAD
  - `load` = 1 and `reg_in` = captured word for exactly one cycle.
  - Then go to SHIFT with counter = 0.
- SHIFT
  - `shift_en` = 1 and `ser_out` = word[counter].
  - Counter is `$clog2(WIDTH)` bits and increments each cycle.
  - When counter = WIDTH-1, go to DONE and clear the counter. It never wraps inside SHIFT.
- DONE
  - `done` = 1 for one cycle, then go to IDLE.
- Outside their states, `reg_in`, `ser_out`, `load`, `shift_en` and `done` are 0. `ack*` is 0 outside IDLE.
- `owner` holds its value until the next handshake.
- Requests arriving while `busy` are not acknowledged. They wait, and are then arbitrated normally in IDLE.
- A requester dropping `req` before ack is legal; no state change.
- Reset asserted mid-transfer: immediate return to reset values. The transfer is abandoned, and no `done` is issued.

## Timing
- Handshake edge = cycle 0.
- LOAD occupies cycle 1.
- SHIFT occupies cycles 2..WIDTH+1.
- DONE is cycle WIDTH+2.
- IDLE is cycle WIDTH+3; the earliest next handshake is on that edge.
- Throughput: one transfer per WIDTH+3 cycles, which is 11 cycles for WIDTH=8.
- `load`, `shift_en`, `ser_out`, `done` and `busy` are registered state decodes. Only `ack*` is combinational.

## Structure
- Package `load_reg_seq_pkg`:
  - state enum (IDLE, LOAD, SHIFT, DONE)
  - default WIDTH constant
  - requester-id type
- Sub-module `rr_arb2`: two-input round-robin arbiter.
  - Inputs: `req[1:0]`, `ptr`, `en`.
  - Output: one-hot `gnt[1:0]`.
  - Purely combinational; the pointer register lives in the parent.

## Test plan
- Reset, then `req0` with `data0` = 8'hA5:
  - `ack0` is high in the same cycle.
  - `load` is high in cycle 1 with `reg_in` = A5.
  - `ser_out` reads 1,0,1,0,0,1,0,1 over cycles 2-9.
  - `done` is high in cycle 10 with `owner` = 0.
- `req0` and `req1` both rise on the same cycle after reset, with data 8'h0F and 8'hF0:
  - Requester 0 is served first, then requester 1 at cycle 11.
  - The second transfer serialises 0,0,0,0,1,1,1,1 with `owner` = 1.
- Both requests held high continuously:
  - Grants alternate 0,1,0,1.
  - Handshakes are exactly 11 cycles apart.
- `req1` asserted at cycle 4 of a requester-0 transfer:
  - `ack1` stays low until cycle 11, then is granted.
- `reset_n` pulled low at cycle 5 (mid-SHIFT):
  - All outputs go to 0 immediately and no `done` is issued.
  - After release, `req1` with 8'h3C completes cleanly.
  - Requester 0 still has priority on the next tie.

Source files
------------

// File: rtl/load_reg_seq_pkg.sv
// -----------------------------------------------------------------------------
// load_reg_seq_pkg
// Shared types and constants for the load-register sequencer:
//   state_t        sequencer FSM encoding (IDLE, LOAD, SHIFT, DONE)
//   DEFAULT_WIDTH  default width of the shared parallel-load register
//   req_id_t       requester identifier (0 or 1)
// -----------------------------------------------------------------------------
package load_reg_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/load_reg_sequencer_arb.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter, purely combinational.
//   req[1:0]  request vector
//   ptr       id of the requester served last; the other one wins a tie
//   en        grants are only issued while enabled
//   gnt[1:0]  one-hot grant (all zero when nothing is granted)
// The pointer register itself lives in the parent.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: default assignment first so every path drives gnt and no latch is inferred.
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/load_reg_sequencer.sv
// -----------------------------------------------------------------------------
// load_reg_sequencer
// Shares the parallel-load register between two requesters. A granted word is
// captured, strobed into the register for one cycle, then serialised LSB-first
// and followed by a one-cycle completion pulse.
//   clock, reset_n      clock and asynchronous active-low reset
//   req0/data0/ack0     requester 0 handshake (ack combinational in IDLE)
//   req1/data1/ack1     requester 1 handshake
//   load, reg_in        one-cycle parallel load strobe and word (LOAD state)
//   shift_en, ser_out   serial phase qualifier and current bit (SHIFT state)
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse (DONE state)
//   owner               requester id of the current or last transfer
// -----------------------------------------------------------------------------
module load_reg_sequencer
  import load_reg_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             load,
  output logic [WIDTH-1:0] reg_in,
  output logic             shift_en,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             owner
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] word;
  req_id_t        ptr;
  req_id_t        owner_q;
  logic           primed;
  logic [1:0]     gnt;
  logic           arb_ptr;
  logic           hs;
  req_id_t        hs_id;

  // Until the first handshake after reset nobody has been served, yet the
  // pointer resets to 0. Presenting "last served = 1" to the arbiter in that
  // window makes requester 0 win the first tie.
  assign arb_ptr = primed ? ptr : 1'b1;

  rr_arb2 u_arb (
    .req (({req1, req0})),
    .ptr (arb_ptr),
    .en  ((state == ST_IDLE)),
    .gnt (gnt)
  );

  // A grant is only issued to an active request, so a grant is a handshake.
  assign hs    = |gnt;
  assign hs_id = gnt[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      word    <= '0;
      ptr     <= 1'b0;
      owner_q <= 1'b0;
      primed  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (hs) begin
            word    <= hs_id ? data1 : data0;
            owner_q <= hs_id;
            ptr     <= hs_id;
            primed  <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Everything except the acks is a decode of registered state.
  assign ack0     = gnt[0];
  assign ack1     = gnt[1];
  assign load     = (state == ST_LOAD);
  assign reg_in   = load ? word : '0;
  assign shift_en = (state == ST_SHIFT);
  assign ser_out  = shift_en & word[cnt];
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign owner    = owner_q;

endmodule
